// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Checksum support is selected with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_e;

  function automatic logic frame_state(state_e s);
    return (s == S_LEN0) || (s == S_LEN1) ||
           (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/loader_timeout_cnt.sv
// Saturating idle counter; hit stays high once LIMIT is reached
// until the next clear.
module loader_timeout_cnt #(
  parameter int unsigned LIMIT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign hit = (cnt_q == W'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !hit)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/imem_loader.sv
// Fills imem from a framed byte stream, then releases the core.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_err
);

  localparam logic [32:0] DEPTH = 33'(1) << ADDR_WIDTH;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e S_FINISH = S_CSUM;
`else
  localparam state_e S_FINISH = S_DONE;
`endif

  state_e                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [15:0]           idx_q, idx_d;
  logic [1:0]            bidx_q, bidx_d;
  logic [23:0]           shift_q, shift_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic        in_frame;
  logic        is_magic;
  logic [15:0] len_full;
  logic        len_big;
  logic        word_done;
  logic        last_word;
  logic        tmo_clr;
  logic        tmo_en;
  logic        tmo_hit;

  assign in_frame  = frame_state(state_q);
  assign is_magic  = rx_valid && (rx_data == LOADER_MAGIC);
  assign len_full  = {rx_data, count_q[7:0]};
  assign len_big   = {17'd0, len_full} > DEPTH;
  assign word_done = (state_q == S_DATA) && rx_valid &&
                     (bidx_q == 2'd3);
  assign last_word = (idx_q == (count_q - 16'd1));
  assign tmo_clr   = rx_valid || !in_frame;
  assign tmo_en    = !tmo_clr;

  loader_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk (clk),
    .rst (rst),
    .clr (tmo_clr),
    .en  (tmo_en),
    .hit (tmo_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      bidx_q      <= '0;
      shift_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      bidx_q      <= bidx_d;
      shift_q     <= shift_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LEN0: begin
        if (rx_valid)     state_d = S_LEN1;
        else if (tmo_hit) state_d = S_ERR;
      end
      S_LEN1: begin
        if (rx_valid) begin
          if (len_full == 16'd0) state_d = S_FINISH;
          else if (len_big)      state_d = S_ERR;
          else                   state_d = S_DATA;
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end
      end
      S_DATA: begin
        if (word_done && last_word)  state_d = S_FINISH;
        else if (!rx_valid && tmo_hit) state_d = S_ERR;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (rx_valid)
          state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        else if (tmo_hit)
          state_d = S_ERR;
      end
`endif
      default: begin
        if (is_magic) state_d = S_LEN0;
      end
    endcase
  end

  always_comb begin
    count_d     = count_q;
    idx_d       = idx_q;
    bidx_d      = bidx_q;
    shift_d     = shift_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    if (rx_valid) begin
      unique case (state_q)
        S_LEN0: count_d[7:0]  = rx_data;
        S_LEN1: count_d[15:8] = rx_data;
        S_DATA: begin
          shift_d = {rx_data, shift_q[23:8]};
          bidx_d  = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ADDR_WIDTH'(BASE_ADDR) +
                          ADDR_WIDTH'(idx_q);
            mem_wdata_d = DATA_WIDTH'({rx_data, shift_q});
            idx_d       = idx_q + 16'd1;
          end
        end
        S_IDLE, S_DONE, S_ERR: begin
          if (is_magic) begin
            count_d = '0;
            idx_d   = '0;
            bidx_d  = '0;
          end
        end
        default: ;
      endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
      // Checksum covers every byte after the magic, excluding itself
      if (in_frame && state_q != S_CSUM)
        csum_d = csum_q ^ rx_data;
      else if (!in_frame)
        csum_d = '0;
`endif
    end
  end

  always_comb begin
    core_hold = (state_q != S_DONE);
    load_done = (state_q == S_DONE);
    load_err  = (state_q == S_ERR);
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Random-frame bench for imem_loader with a queue-based write model.
// Runs in either build of IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  localparam int AW    = 12;
  localparam int TMO   = 40;
  localparam int BASE  = 0;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_hold;
  logic          load_done;
  logic          load_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]   words_q[$];
  logic [AW-1:0] got_a[$];
  logic [31:0]   got_d[$];

  imem_loader #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (32),
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_a.push_back(mem_addr);
      got_d.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_writes();
    chk("n_writes", 64'(got_a.size()), 64'(words_q.size()));
    if (got_a.size() == words_q.size()) begin
      foreach (words_q[i]) begin
        chk("wr_addr", 64'(got_a[i]), 64'((BASE + i) % DEPTH));
        chk("wr_data", 64'(got_d[i]), 64'(words_q[i]));
      end
    end
  endtask

  // gap < 0 selects a random idle gap per byte.
  task automatic run_frame(input int gap);
    logic [7:0] b[$];
    logic [7:0] cs;
    int         n;
    int         g;
    n = words_q.size();
    got_a.delete();
    got_d.delete();
    b.push_back(8'hA5);
    b.push_back(n[7:0]);
    b.push_back(n[15:8]);
    foreach (words_q[i])
      for (int k = 0; k < 4; k++)
        b.push_back(words_q[i][8*k +: 8]);
    cs = 8'h00;
    for (int i = 1; i < b.size(); i++) cs ^= b[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
    b.push_back(cs);
`endif
    for (int i = 0; i < b.size() - 1; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      send_byte(b[i], g);
    end
    chk("hold_pre", 64'(core_hold), 64'(1));
    send_byte(b[b.size() - 1], 0);
    chk("done", 64'(load_done), 64'(1));
    chk("hold_rel", 64'(core_hold), 64'(0));
    chk("no_err", 64'(load_err), 64'(0));
    repeat (2) @(negedge clk);
    check_writes();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_we", 64'(mem_we), 64'(0));
    chk("rst_addr", 64'(mem_addr), 64'(0));
    chk("rst_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_hold", 64'(core_hold), 64'(1));
    chk("rst_done", 64'(load_done), 64'(0));
    chk("rst_err", 64'(load_err), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Non-magic bytes in IDLE are ignored
    got_a.delete();
    send_byte(8'h55, 1);
    send_byte(8'h00, 3);
    chk("idle_wr", 64'(got_a.size()), 64'(0));
    chk("idle_hold", 64'(core_hold), 64'(1));
    chk("idle_done", 64'(load_done), 64'(0));

    words_q = '{32'h0000_0013, 32'h0010_0093};
    run_frame(1);

    words_q.delete();
    run_frame(0);

    // Partial frame then silence
    got_a.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    repeat (TMO - 4) @(negedge clk);
    chk("tmo_early", 64'(load_err), 64'(0));
    repeat (8) @(negedge clk);
    chk("tmo_err", 64'(load_err), 64'(1));
    chk("tmo_hold", 64'(core_hold), 64'(1));
    chk("tmo_wr", 64'(got_a.size()), 64'(0));
    words_q = '{32'h0000_0013};
    run_frame(0);

    // Count one past the memory depth
    got_a.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    chk("big_err", 64'(load_err), 64'(1));
    chk("big_hold", 64'(core_hold), 64'(1));
    chk("big_done", 64'(load_done), 64'(0));
    repeat (3) @(negedge clk);
    chk("big_wr", 64'(got_a.size()), 64'(0));

`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h12, 0);
    chk("cs_ok_done", 64'(load_done), 64'(1));
    chk("cs_ok_hold", 64'(core_hold), 64'(0));
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    chk("cs_bad_err", 64'(load_err), 64'(1));
    chk("cs_bad_hold", 64'(core_hold), 64'(1));
    chk("cs_bad_done", 64'(load_done), 64'(0));
`endif

    // Asynchronous reset in the middle of DATA
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_wdata", 64'(mem_wdata), 64'(0));
    chk("mid_rst_hold", 64'(core_hold), 64'(1));
    chk("mid_rst_we", 64'(mem_we), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    words_q = '{32'h0000_0013, 32'h0010_0093};
    run_frame(0);

    for (int t = 0; t < 8; t++) begin
      words_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++)
        words_q.push_back(($urandom_range(0, 3) == 0) ?
                          32'hA5A5_A5A5 : $urandom());
      run_frame(-1);
    end

    // Count exactly equal to the memory depth
    words_q.delete();
    for (int i = 0; i < DEPTH; i++) words_q.push_back($urandom());
    run_frame(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
